// File: rtl/cmd_feeder.sv
// Program RAM plus instruction sequencer for the cpu command port, with a
// result FIFO that captures every executed `out` for the host to drain.
module cmd_feeder #(
  parameter int ADDR_W  = 8,
  parameter int FIFO_AW = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       cmd_id,
  input  logic [31:0]       res,
  input  logic              res_en,
  output logic [31:0]       cmd,
  output logic              cmd_en,
  output logic              busy,
  output logic              done,
  output logic [31:0]       res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_ovf
);

  typedef enum logic [1:0] {IDLE, FETCH, RUN, DONE} state_t;

  state_t             state;
  logic [31:0]        mem [2**ADDR_W];
  logic [31:0]        fifo_mem [2**FIFO_AW];
  logic [FIFO_AW:0]   wr_ptr;
  logic [FIFO_AW:0]   rd_ptr;
  logic [ADDR_W-1:0]  idx;
  logic               out_of_range;
  logic               launch;
  logic               push;
  logic               pop;
  logic               full;
  logic               wr_ok;

  assign idx          = cmd_id[ADDR_W-1:0];
  assign out_of_range = |cmd_id[15:ADDR_W];
  assign launch       = start && (state == IDLE || state == DONE);

  // A registered cmd_en qualifies res_en: it means the core just executed an
  // instruction from us, so a high res_en is fresh rather than left over.
  assign push  = res_en && cmd_en;
  assign pop   = res_valid && res_ready;
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign wr_ok = push && (!full || pop);

  assign res_valid = (wr_ptr != rd_ptr);
  assign res_data  = fifo_mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge sys_clk) begin
    if (prog_we && !busy) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state  <= IDLE;
      cmd    <= '0;
      cmd_en <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        FETCH: begin
          cmd    <= mem[idx];
          cmd_en <= 1'b0;
          state  <= RUN;
        end
        RUN: begin
          if (stop || out_of_range) begin
            cmd_en <= 1'b0;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            cmd    <= mem[idx];
            cmd_en <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          cmd_en <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_ok) begin
      fifo_mem[wr_ptr[FIFO_AW-1:0]] <= res;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      res_ovf <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (launch) begin
        res_ovf <= 1'b0;
      end else if (push && full && !pop) begin
        res_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_feeder.sv
// Bench for cmd_feeder: a tiny instruction-level core model drives cmd_id/res,
// and an instruction-set interpreter predicts the captured result stream.
module tb_cmd_feeder;
  localparam int ADDR_W  = 8;
  localparam int FIFO_AW = 3;
  localparam logic [7:0] OP_WL = 8'h01, OP_OUT = 8'h02, OP_JMP = 8'h03;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] cmd_id;
  logic [31:0] res;
  logic        res_en;
  logic [31:0] cmd;
  logic        cmd_en;
  logic        busy;
  logic        done;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        res_ovf;

  logic        ready_force = 1'b0;
  logic        pp_mode = 1'b0;
  logic        stale_res = 1'b0;
  logic        set_pc_req = 1'b0;
  logic [15:0] set_pc_val = '0;

  int checks = 0;
  int failures = 0;
  logic [31:0] shadow [256];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  rsel;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [4];

  assign res_ready = ready_force | (pp_mode & res_en & cmd_en);

  cmd_feeder #(.ADDR_W(ADDR_W), .FIFO_AW(FIFO_AW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .stop(stop), .cmd_id(cmd_id), .res(res),
    .res_en(res_en), .cmd(cmd), .cmd_en(cmd_en), .busy(busy), .done(done),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .res_ovf(res_ovf)
  );

  always #5 sys_clk = ~sys_clk;

  // Core model: executes the presented instruction at each negedge with cmd_en.
  logic [15:0] pc = '0;
  logic [31:0] rf [4];
  logic [31:0] res_q = '0;
  logic        res_en_q = 1'b0;
  assign cmd_id = pc;
  assign res    = res_q;
  assign res_en = res_en_q;

  always @(negedge sys_clk) begin
    if (set_pc_req) begin
      pc = set_pc_val;
    end else if (cmd_en) begin
      case (cmd[7:0])
        OP_WL:   begin rf[cmd[9:8]] = {16'h0, cmd[31:16]}; res_en_q = 1'b0; pc = pc + 16'd1; end
        OP_OUT:  begin res_q = rf[cmd[9:8]]; res_en_q = 1'b1; pc = pc + 16'd1; end
        OP_JMP:  begin pc = cmd[31:16]; res_en_q = 1'b0; end
        default: begin res_en_q = 1'b0; pc = pc + 16'd1; end
      endcase
    end
    if (stale_res) res_en_q = 1'b1;
  end

  function automatic logic [31:0] enc_wl(input logic [1:0] r, input logic [15:0] imm);
    return {imm, 6'b0, r, OP_WL};
  endfunction
  function automatic logic [31:0] enc_out(input logic [1:0] r);
    return {16'h0, 6'b0, r, OP_OUT};
  endfunction
  function automatic logic [31:0] enc_jmp(input logic [15:0] t);
    return {t, 8'h0, OP_JMP};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge sys_clk); #1;
    prog_we = 1'b0;
    shadow[a] = d;
  endtask

  task automatic set_pc(input logic [15:0] v);
    set_pc_val = v; set_pc_req = 1'b1;
    @(negedge sys_clk); #1;
    set_pc_req = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic run_at(input logic [15:0] spc, input int budget);
    set_pc(spc);
    pulse_start();
    wait_done(budget);
  endtask

  task automatic drain(input string name);
    foreach (exp_q[i]) begin
      check({name, "_valid"}, 32'(res_valid), 32'd1);
      check({name, "_data"}, res_data, exp_q[i]);
      ready_force = 1'b1;
      @(posedge sys_clk); #1;
      ready_force = 1'b0;
    end
    check({name, "_empty"}, 32'(res_valid), 32'd0);
  endtask

  // Instruction-level interpreter over the bench's copy of the program.
  task automatic iss(input logic [15:0] spc);
    logic [15:0] p;
    logic [31:0] r [4];
    logic [31:0] w;
    p = spc;
    for (int k = 0; k < 4; k++) r[k] = '0;
    exp_q.delete();
    for (int s = 0; s < 1000; s++) begin
      if (p >= 16'(1 << ADDR_W)) break;
      w = shadow[p[7:0]];
      if (w[7:0] == OP_WL) begin r[w[9:8]] = {16'h0, w[31:16]}; p = p + 16'd1; end
      else if (w[7:0] == OP_OUT) begin exp_q.push_back(r[w[9:8]]); p = p + 16'd1; end
      else if (w[7:0] == OP_JMP) p = w[31:16];
      else p = p + 16'd1;
    end
  endtask

  initial begin
    logic [15:0] a;
    int len;
    int sel;
    logic ovf_exp;

    vecs[0] = '{imm: 16'h0005, rsel: 2'd1, exp: 32'h0000_0005};
    vecs[1] = '{imm: 16'hFFFF, rsel: 2'd2, exp: 32'h0000_FFFF};
    vecs[2] = '{imm: 16'h0000, rsel: 2'd0, exp: 32'h0000_0000};
    vecs[3] = '{imm: 16'h8001, rsel: 2'd3, exp: 32'h0000_8001};

    // Reset values
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    check("rst_cmd", cmd, 32'h0);
    check("rst_cmd_en", 32'(cmd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_ovf", 32'(res_ovf), 32'd0);

    // Load and run with exact issue timing
    load(8'h00, enc_wl(2'd1, 16'd5));
    load(8'h01, enc_out(2'd1));
    load(8'h02, enc_jmp(16'h0100));
    set_pc(16'h0000);
    pulse_start();
    check("e0_busy", 32'(busy), 32'd1);
    check("e0_cmd_en", 32'(cmd_en), 32'd0);
    @(posedge sys_clk); #1;
    check("e1_cmd_en", 32'(cmd_en), 32'd0);
    check("e1_cmd", cmd, enc_wl(2'd1, 16'd5));
    @(posedge sys_clk); #1;
    check("e2_cmd_en", 32'(cmd_en), 32'd1);
    @(posedge sys_clk); #1;
    check("e3_cmd", cmd, enc_out(2'd1));
    @(posedge sys_clk); #1;
    check("e4_res_valid", 32'(res_valid), 32'd1);
    @(posedge sys_clk); #1;
    check("e5_cmd_en", 32'(cmd_en), 32'd0);
    check("e5_done", 32'(done), 32'd1);
    check("e5_busy", 32'(busy), 32'd0);
    exp_q = '{32'd5};
    drain("first");

    // Table of single-result programs
    for (int i = 0; i < 4; i++) begin
      load(8'hE0, enc_wl(vecs[i].rsel, vecs[i].imm));
      load(8'hE1, enc_out(vecs[i].rsel));
      load(8'hE2, enc_jmp(16'h0100));
      run_at(16'h00E0, 100);
      exp_q = '{vecs[i].exp};
      drain("vec");
    end

    // Back-to-back outs
    load(8'h08, enc_wl(2'd1, 16'd1));
    load(8'h09, enc_wl(2'd2, 16'd2));
    load(8'h0A, enc_wl(2'd3, 16'd3));
    load(8'h0B, enc_out(2'd1));
    load(8'h0C, enc_out(2'd2));
    load(8'h0D, enc_out(2'd3));
    load(8'h0E, enc_jmp(16'h0100));
    run_at(16'h0008, 100);
    exp_q = '{32'd1, 32'd2, 32'd3};
    drain("b2b");

    // Overflow: nine results into an eight-deep FIFO
    for (int k = 0; k < 9; k++) begin
      load(8'(8'h90 + 2 * k), enc_wl(2'd1, 16'(k + 1)));
      load(8'(8'h91 + 2 * k), enc_out(2'd1));
    end
    load(8'hA2, enc_jmp(16'h0100));
    run_at(16'h0090, 100);
    check("ovf_set", 32'(res_ovf), 32'd1);
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    drain("ovf");
    check("ovf_sticky", 32'(res_ovf), 32'd1);

    // Fill to full, then push and pop together while full
    for (int k = 0; k < 8; k++) begin
      load(8'(8'h50 + 2 * k), enc_wl(2'd1, 16'(k + 1)));
      load(8'(8'h51 + 2 * k), enc_out(2'd1));
    end
    load(8'h60, enc_jmp(16'h0100));
    run_at(16'h0050, 100);
    check("fill_ovf_clr", 32'(res_ovf), 32'd0);
    check("fill_valid", 32'(res_valid), 32'd1);
    load(8'h70, enc_wl(2'd1, 16'h00A1));
    load(8'h71, enc_wl(2'd2, 16'h00A2));
    load(8'h72, enc_wl(2'd3, 16'h00A3));
    load(8'h73, enc_out(2'd1));
    load(8'h74, enc_out(2'd2));
    load(8'h75, enc_out(2'd3));
    load(8'h76, enc_jmp(16'h0100));
    pp_mode = 1'b1;
    run_at(16'h0070, 100);
    pp_mode = 1'b0;
    check("pp_ovf", 32'(res_ovf), 32'd0);
    exp_q = '{32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'hA1, 32'hA2, 32'hA3};
    drain("pp");

    // Stop, stale res_en, and write blocking while busy
    load(8'h10, enc_jmp(16'h0010));
    load(8'h20, enc_wl(2'd2, 16'h0055));
    load(8'h21, enc_out(2'd2));
    load(8'h22, enc_jmp(16'h0100));
    set_pc(16'h0010);
    pulse_start();
    repeat (4) @(posedge sys_clk);
    #1;
    check("loop_cmd_en", 32'(cmd_en), 32'd1);
    prog_we = 1'b1; prog_addr = 8'h21; prog_data = 32'h0;
    @(posedge sys_clk); #1;
    prog_we = 1'b0;
    stop = 1'b1;
    @(posedge sys_clk); #1;
    stop = 1'b0;
    check("stop_cmd_en", 32'(cmd_en), 32'd0);
    check("stop_done", 32'(done), 32'd1);
    check("stop_busy", 32'(busy), 32'd0);
    stale_res = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    stale_res = 1'b0;
    check("stale_nopush", 32'(res_valid), 32'd0);
    run_at(16'h0020, 100);
    exp_q = '{32'h55};
    drain("wblock");

    // Reset in the middle of a run
    load(8'h40, enc_wl(2'd1, 16'h0011));
    load(8'h41, enc_out(2'd1));
    load(8'h42, enc_jmp(16'h0010));
    set_pc(16'h0040);
    pulse_start();
    repeat (8) @(posedge sys_clk);
    #1;
    check("mid_valid", 32'(res_valid), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    check("mrst_cmd", cmd, 32'h0);
    check("mrst_cmd_en", 32'(cmd_en), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_valid", 32'(res_valid), 32'd0);
    check("mrst_ovf", 32'(res_ovf), 32'd0);

    // Random straight-line programs against the interpreter
    for (int it = 0; it < 8; it++) begin
      a = 16'h00B0;
      for (int r = 0; r < 4; r++) begin
        load(a[7:0], enc_wl(2'(r), 16'($urandom)));
        a = a + 16'd1;
      end
      len = $urandom_range(4, 40);
      for (int k = 0; k < len; k++) begin
        sel = $urandom_range(0, 2);
        if (sel == 0) load(a[7:0], enc_wl(2'($urandom_range(0, 3)), 16'($urandom)));
        else if (sel == 1) load(a[7:0], enc_out(2'($urandom_range(0, 3))));
        else load(a[7:0], 32'h0);
        a = a + 16'd1;
      end
      load(a[7:0], enc_jmp(16'h0100));
      iss(16'h00B0);
      ovf_exp = (exp_q.size() > 8);
      while (exp_q.size() > 8) void'(exp_q.pop_back());
      run_at(16'h00B0, 200);
      check("rnd_ovf", 32'(res_ovf), 32'(ovf_exp));
      drain("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
